// File: rtl/dct_col.sv
// rtl/dct_col.sv - 8-point 1-D DCT over a serially captured column of samples
//
// Purpose:
//    Eight signed samples are captured one at a time. When the eighth arrives,
//    the block is transformed with 6-bit fixed-point cosine coefficients. The
//    result is rounded, saturated and registered one cycle later.
//
// Ports:
//    clk        in   clock; every register updates on the rising edge
//    rst        in   synchronous, active-high reset
//    data_in    in   SIZE-bit signed sample
//    start      in   block enable; low clears the sample counter (partial block lost)
//    wr_en      in   sample write strobe; captures only when start is high
//    approx_en  in   truncated-product multiply-accumulate (only with the macro)
//    data_out   out  8 x SIZE_OUT signed registered coefficients Y[0..7]
//    done       out  one-cycle pulse marking a data_out update
//
// Configuration macro:
//    DCT_COL_APPROX_EN  defined: approx_en=1 clears the low APPROX_BITS bits of
//                       every product before accumulation.
//                       undefined: approx_en is ignored and results are exact.

module dct_col #(
   parameter int SIZE        = 8,
   parameter int APPROX_BITS = 0,
   parameter int SIZE_MULT   = SIZE + 6,
   parameter int SIZE_OUT    = SIZE + 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SIZE-1:0]     data_in,
   input  logic                       start,
   input  logic                       wr_en,
   input  logic                       approx_en,
   output logic signed [SIZE_OUT-1:0] data_out [7:0],
   output logic                       done
);

   localparam int ACC_W = SIZE_MULT + 3;
   localparam logic [SIZE_MULT-1:0]    P_MASK  = {SIZE_MULT{1'b1}} << APPROX_BITS;
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 <<< (SIZE_OUT - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 <<< (SIZE_OUT - 1)));

   // c(k,n) = round(32*cos((2n+1)*k*pi/16)), with row 0 fixed at 23.
   // The angle index m is in units of pi/16. It is folded into 0..16 by
   // cos(2pi - a) = cos(a), and then into 0..8 by cos(pi - a) = -cos(a).
   // For k = 1..7, m is never a multiple of 8, so the magnitudes 32 and 0
   // are never needed.
   function automatic int coef(input int k, input int n);
      int m;
      int sgn;
      int mag;
      if (k == 0) return 23;
      m   = ((2 * n + 1) * k) % 32;
      sgn = 1;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
         m   = 16 - m;
         sgn = -1;
      end
      case (m)
         1:       mag = 31;
         2:       mag = 30;
         3:       mag = 27;
         4:       mag = 23;
         5:       mag = 18;
         6:       mag = 12;
         7:       mag = 6;
         default: mag = 0;
      endcase
      return sgn * mag;
   endfunction

   logic                       approx_act;
`ifdef DCT_COL_APPROX_EN
   assign approx_act = approx_en;
`else
   logic                       unused_approx_en;
   assign unused_approx_en = approx_en;
   assign approx_act       = 1'b0;
`endif

   logic        [2:0]          cnt_q, cnt_d;
   logic signed [SIZE-1:0]     x_q [8];
   logic signed [SIZE-1:0]     x_d [8];
   logic                       pend_q, pend_d;
   logic signed [SIZE_OUT-1:0] out_q [7:0];
   logic signed [SIZE_OUT-1:0] out_d [7:0];
   logic                       done_q, done_d;
   logic signed [SIZE_OUT-1:0] y [8];
   logic signed [SIZE_MULT-1:0] p;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    sh;

   // The transform reads the sample buffer on the edge after the eighth
   // capture. A capture for the next block can land on that same edge and
   // overwrite x[0]. The transform still sees the old x[0], because the
   // buffer holds its pre-edge value for the whole cycle.
   always_comb begin
      p   = '0;
      acc = '0;
      sh  = '0;
      for (int k = 0; k < 8; k++) begin
         acc = '0;
         for (int n = 0; n < 8; n++) begin
            p = SIZE_MULT'(x_q[n]) * SIZE_MULT'(coef(k, n));
            if (approx_act) p = p & P_MASK;
            acc = acc + ACC_W'(p);
         end
         sh = (acc + ACC_W'(32)) >>> 6;
         if (sh > OUT_MAX)      y[k] = OUT_MAX[SIZE_OUT-1:0];
         else if (sh < OUT_MIN) y[k] = OUT_MIN[SIZE_OUT-1:0];
         else                   y[k] = sh[SIZE_OUT-1:0];
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      x_d    = x_q;
      pend_d = 1'b0;
      out_d  = out_q;
      done_d = pend_q;
      if (!start) begin
         cnt_d = 3'd0;
      end else if (wr_en) begin
         x_d[cnt_q] = data_in;
         cnt_d      = cnt_q + 3'd1;
         pend_d     = (cnt_q == 3'd7);
      end
      if (pend_q) begin
         for (int k = 0; k < 8; k++) out_d[k] = y[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 3'd0;
         pend_q <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            x_q[i]   <= '0;
            out_q[i] <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         x_q    <= x_d;
         pend_q <= pend_d;
         out_q  <= out_d;
         done_q <= done_d;
      end
   end

   assign data_out = out_q;
   assign done     = done_q;

endmodule

// File: tb/tb_dct_col.sv
// tb/tb_dct_col.sv - directed self-checking bench for dct_col
module tb_dct_col;

   localparam int SO = 10;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 wr_en;
   logic                 approx_en;
   logic signed [7:0]    data_in;
   logic signed [SO-1:0] data_out [7:0];
   logic                 done;

   int checks = 0;
   int errors = 0;
   logic signed [7:0]    blk [8];
   int                   exp_y [8];

   always #5 clk = ~clk;

   dct_col #(.SIZE(8), .APPROX_BITS(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start), .wr_en(wr_en),
      .approx_en(approx_en), .data_out(data_out), .done(done)
   );

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; data_in = '0;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic capture(input logic signed [7:0] v);
      start = 1'b1; wr_en = 1'b1; data_in = v;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic send_block();
      for (int i = 0; i < 8; i++) capture(blk[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; wr_en = 1'b1; data_in = 8'sd55; approx_en = 1'b0;
      idle(3);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b want 0", done);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (data_out[k] !== '0) begin
            errors++; $display("FAIL reset_out[%0d]: got %0d want 0", k, data_out[k]);
         end
      end
      rst = 1'b0; start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_constant();
      do_reset();
      for (int i = 0; i < 8; i++) blk[i] = 8'sd10;
      exp_y = '{29, 0, 0, 0, 0, 0, 0, 0};
      send_block();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL const_early_done: got %b want 0", done);
      end
      idle(1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL const_done: got %b want 1", done);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (data_out[k] !== SO'(exp_y[k])) begin
            errors++; $display("FAIL const_y[%0d]: got %0d want %0d", k, data_out[k], exp_y[k]);
         end
      end
      idle(2);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL const_done_width: got %b want 0", done);
      end
      checks++;
      if (data_out[0] !== SO'(29)) begin
         errors++; $display("FAIL const_hold: got %0d want 29", data_out[0]);
      end
   endtask

   task automatic test_impulse();
      do_reset();
      blk = '{8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
      exp_y = '{23, 31, 30, 27, 23, 18, 12, 6};
      send_block();
      idle(1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL impulse_done: got %b want 1", done);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (data_out[k] !== SO'(exp_y[k])) begin
            errors++; $display("FAIL impulse_y[%0d]: got %0d want %0d", k, data_out[k], exp_y[k]);
         end
      end
   endtask

   task automatic test_extremes();
      int want0;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < 8; i++) blk[i] = (pass == 0) ? -8'sd128 : 8'sd127;
         want0 = (pass == 0) ? -368 : 365;
         send_block();
         idle(1);
         checks++;
         if (data_out[0] !== SO'(want0)) begin
            errors++; $display("FAIL extreme%0d_y0: got %0d want %0d", pass, data_out[0], want0);
         end
         for (int k = 1; k < 8; k++) begin
            checks++;
            if (data_out[k] !== '0) begin
               errors++; $display("FAIL extreme%0d_y[%0d]: got %0d want 0", pass, k, data_out[k]);
            end
         end
      end
   endtask

   task automatic fresh_block_check(input string tag);
      for (int i = 0; i < 8; i++) begin
         capture(8'sd10);
         checks++;
         if (done !== 1'b0 || data_out[0] !== '0) begin
            errors++;
            $display("FAIL %s_quiet%0d: got done=%b y0=%0d want done=0 y0=0", tag, i, done, data_out[0]);
         end
      end
      idle(1);
      checks++;
      if (done !== 1'b1 || data_out[0] !== SO'(29)) begin
         errors++;
         $display("FAIL %s_result: got done=%b y0=%0d want done=1 y0=29", tag, done, data_out[0]);
      end
   endtask

   task automatic test_abort_start();
      do_reset();
      for (int i = 0; i < 5; i++) capture(8'sd50);
      start = 1'b0; wr_en = 1'b1; data_in = 8'sd99;
      idle(1);
      wr_en = 1'b0;
      fresh_block_check("abort_start");
   endtask

   task automatic test_abort_reset();
      do_reset();
      for (int i = 0; i < 3; i++) capture(8'sd50);
      rst = 1'b1; start = 1'b1; wr_en = 1'b1; data_in = 8'sd99;
      idle(1);
      rst = 1'b0; wr_en = 1'b0;
      fresh_block_check("abort_reset");
   endtask

   task automatic test_gapped();
      int pulses;
      int at;
      do_reset();
      pulses = 0;
      at = -1;
      for (int cyc = 0; cyc < 67; cyc++) begin
         start = 1'b1;
         wr_en = (cyc < 64) && (cyc % 8 == 0);
         data_in = 8'sd10;
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            pulses++;
            at = cyc;
         end
      end
      wr_en = 1'b0;
      checks++;
      if (pulses != 1 || at != 57) begin
         errors++; $display("FAIL gapped_pulses: got %0d at cycle %0d want 1 at cycle 57", pulses, at);
      end
      checks++;
      if (data_out[0] !== SO'(29) || data_out[4] !== '0) begin
         errors++; $display("FAIL gapped_y: got y0=%0d y4=%0d want 29 0", data_out[0], data_out[4]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      blk = '{8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
      exp_y = '{23, 31, 30, 27, 23, 18, 12, 6};
      send_block();
      for (int i = 0; i < 8; i++) begin
         capture(8'sd10);
         if (i == 0) begin
            checks++;
            if (done !== 1'b1) begin
               errors++; $display("FAIL b2b_first_done: got %b want 1", done);
            end
            for (int k = 0; k < 8; k++) begin
               checks++;
               if (data_out[k] !== SO'(exp_y[k])) begin
                  errors++; $display("FAIL b2b_first_y[%0d]: got %0d want %0d", k, data_out[k], exp_y[k]);
               end
            end
         end else begin
            checks++;
            if (done !== 1'b0) begin
               errors++; $display("FAIL b2b_gap_done%0d: got %b want 0", i, done);
            end
         end
      end
      idle(1);
      checks++;
      if (done !== 1'b1 || data_out[0] !== SO'(29) || data_out[1] !== '0) begin
         errors++;
         $display("FAIL b2b_second: got done=%b y0=%0d y1=%0d want 1 29 0", done, data_out[0], data_out[1]);
      end
   endtask

   task automatic test_approx();
      int want_on;
`ifdef DCT_COL_APPROX_EN
      want_on = 2;
`else
      want_on = 3;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         approx_en = (pass == 0);
         for (int i = 0; i < 8; i++) blk[i] = 8'sd1;
         send_block();
         idle(1);
         checks++;
         if (data_out[0] !== SO'((pass == 0) ? want_on : 3)) begin
            errors++;
            $display("FAIL approx_en%0d_y0: got %0d want %0d", approx_en, data_out[0], (pass == 0) ? want_on : 3);
         end
      end
      approx_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; approx_en = 1'b0; data_in = '0;
      test_reset();
      test_constant();
      test_impulse();
      test_extremes();
      test_abort_start();
      test_abort_reset();
      test_gapped();
      test_back_to_back();
      test_approx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct_col.md
DCT_COL -- requirements
Module: dct_col

Interface
REQ-001 Parameter SIZE, default 8: signed input sample width.
REQ-002 Parameter APPROX_BITS, default 0: number of product LSBs cleared when approximation is active.
REQ-003 Parameter SIZE_MULT, default SIZE+6: signed width of each coefficient product.
REQ-004 Parameter SIZE_OUT, default SIZE+2: signed width of each output coefficient.
REQ-005 clk  input  1  clock; every register updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 data_in  input  SIZE signed  one sample, presented serially.
REQ-008 start  input  1  block-enable; low aborts any partial block.
REQ-009 wr_en  input  1  sample write strobe.
REQ-010 approx_en  input  1  selects approximate multiply-accumulate (see Configuration).
REQ-011 data_out[7:0]  output  8 x SIZE_OUT signed  registered 1-D DCT coefficients Y[0]..Y[7].
REQ-012 done  output  1  one-cycle pulse; data_out updated this cycle.

Function
REQ-013 A capture occurs on a rising edge with start=1 and wr_en=1; data_in is stored as x[n] with n = 3-bit sample counter, and the counter then increments.
REQ-014 wr_en=1 with start=0 is ignored; start=0 on any edge clears the sample counter to 0 and leaves data_out unchanged.
REQ-015 Capture strobes need not be consecutive; idle cycles (wr_en=0) hold the counter and buffer.
REQ-016 On the edge capturing x[7] the counter wraps to 0; on the next edge data_out is loaded with Y[0..7] and done is 1 for exactly that one cycle (latency 1 cycle after the 8th capture).
REQ-017 A new block may begin capturing on the edge after the 8th capture; its captures do not corrupt the pending computation, which latches all 8 samples before the next capture overwrites x[0].
REQ-018 Coefficients c(0,n)=23 for all n; c(k,n)=round(32*cos((2n+1)*k*pi/16)) for k=1..7, magnitudes {31,30,27,23,18,12,6} for cos arguments pi/16..7pi/16, with the sign of the cosine.
REQ-019 Product p(k,n)=x[n]*c(k,n), signed, SIZE_MULT bits; acc(k)=sum over n of p(k,n), signed, SIZE_MULT+3 bits, no overflow.
REQ-020 Y[k]=(acc(k)+32) arithmetically shifted right by 6, then saturated to the signed SIZE_OUT range.
REQ-021 data_out holds its value between done pulses.

Reset
REQ-022 While rst=1: sample counter=0, sample buffer=0, data_out all 0, done=0; rst overrides start and wr_en on the same edge.
REQ-023 Reset asserted mid-block discards all captured samples; the next capture after reset is x[0].

Configuration
REQ-024 Macro DCT_COL_APPROX_EN defined: when approx_en=1, each p(k,n) has its low APPROX_BITS bits forced to 0 (two's complement, i.e. floor to a multiple of 2^APPROX_BITS) before accumulation; approx_en=0 gives exact results.
REQ-025 Macro DCT_COL_APPROX_EN undefined: approx_en is ignored and results are always exact.

Verification
REQ-026 Constant block: x[n]=10 for all n -> data_out = {29,0,0,0,0,0,0,0}, done pulse 1 cycle after the 8th capture.
REQ-027 Impulse: x[0]=64, others 0 -> Y[0..7] = {23,31,30,27,23,18,12,6}.
REQ-028 Extremes (SIZE=8): all x=-128 -> Y[0]=-368; all x=127 -> Y[0]=365; Y[1..7]=0 in both cases.
REQ-029 Aborts: start dropped after 5 captures, then 8 fresh captures of value 10 -> Y[0]=29. rst after 3 captures, then 8 fresh captures of value 10 -> Y[0]=29. data_out stays 0 and done stays 0 until the 8th fresh capture.
REQ-030 Gapped strobes: wr_en asserted one cycle in eight for 64 cycles -> same result as 8 consecutive captures; exactly one done pulse.
REQ-031 Approximation (macro defined, APPROX_BITS=4): all x=1 with approx_en=1 -> Y[0]=2; with approx_en=0 -> Y[0]=3. Macro undefined -> Y[0]=3 in both cases.
